mlp_sequencer: RTL and testbench
================================

# mlp_sequencer

Parametrised two-layer inference sequencer for the digit-recognizer datapath. It generalises the fixed 36-input / 8-hidden / 10-output network controller: layer sizes, lane count and data width are parameters. Weight fetch uses a valid handshake instead of a fixed flash-cycle count, and a synchronous abort is added. It sits between the pixel buffer, weight flash, activation (sigmoid) RAM and the multiply-accumulate ALU, and issues one accumulate per LANES-wide input group.

## Interface
- DATA_W, 4: width of one input, weight, bias or activation
- LANES, 4: inputs/weights consumed per accumulate
- L1_GROUPS, 36: input groups per layer-1 neuron (pixel groups)
- L1_NEURONS, 8: hidden neurons
- L2_NEURONS, 10: output neurons
- ADDR_W, 16: weight-memory address width
- ACT_AW, 5: activation RAM address width; L1_NEURONS+L2_NEURONS <= 2**ACT_AW
- Derived: L2_GROUPS = ceil(L1_NEURONS/LANES); G_W = clog2(max(L1_GROUPS,L2_GROUPS))

Ports:
- clk  in  1  clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  begin inference; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE next cycle, no done
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, inference complete
- mem_req  out  1  weight/bias word request
- mem_addr  out  ADDR_W  word address, stable while mem_req high
- mem_valid  in  1  mem_data valid this cycle; ignored when mem_req low
- mem_data  in  LANES*DATA_W  weight word (lane k = bits k*DATA_W+:DATA_W); bias = bits [DATA_W-1:0]
- pix_req  out  1  pixel-group read strobe
- pix_group  out  G_W  pixel group index
- pix_data  in  LANES*DATA_W  pixel group, valid the cycle after pix_req
- act_rd_addr  out  ACT_AW  activation read address; data valid next cycle
- act_rd_data  in  DATA_W  activation read data
- act_wr_en  out  1  activation write strobe
- act_wr_addr  out  ACT_AW  write address
- act_wr_data  out  DATA_W  equals alu_result
- alu_result  in  DATA_W  sigmoid(accumulator), valid the cycle after accumulate
- weights, inputs  out  LANES*DATA_W  registered operands to ALU
- bias  out  DATA_W  registered bias
- clear, accumulate  out  1  ALU control
- layer  out  1  0 = hidden layer, 1 = output layer

## Operation
- States: IDLE, BIAS, WEIGHT, IN_REQ, IN_CAP, ACCU, WRITE, DONE.
- Counters: neuron n, group g, lane k (layer 1 only), address a. All cleared on start and in IDLE.
- IDLE: start=1 -> BIAS with layer=0, n=0.
- BIAS: mem_req=1, clear=1, g=0. On mem_valid: capture bias, a++, go to WEIGHT.
- WEIGHT: mem_req=1. On mem_valid: capture weights, a++, go to IN_REQ.
- IN_REQ, layer 0: pix_req=1, pix_group=g, go to IN_CAP.
- IN_REQ, layer 1: act_rd_addr=g*LANES+k, go to IN_CAP.
- IN_CAP, layer 0: capture all lanes from pix_data, go to ACCU.
- IN_CAP, layer 1: capture lane k from act_rd_data. Lanes with g*LANES+k >= L1_NEURONS load 0 but are still sequenced. k++; after k=LANES-1, set k=0 and go to ACCU, else go to IN_REQ.
- ACCU: accumulate=1 for one cycle. Last group -> WRITE; otherwise g++ -> WEIGHT.
- WRITE: act_wr_en=1. act_wr_addr = n (layer 0) or L1_NEURONS+n (layer 1).
  - n < last: n++ -> BIAS.
  - Layer 0 last: layer=1, n=0 -> BIAS.
  - Layer 1 last: -> DONE.
- DONE: done=1 -> IDLE.
- Weight memory layout, contiguous from address 0: per neuron one bias word, then that neuron's group words. Layer-1 words follow layer-0 words. Total words = L1_NEURONS*(1+L1_GROUPS) + L2_NEURONS*(1+L2_GROUPS).
- abort (any state) beats every other transition: next state IDLE, counters cleared, no write, no done. start is ignored while busy.

## Timing
- Reset: every output 0; state IDLE; operand registers 0.
- mem_req stays high, with mem_addr fixed, until mem_valid. Zero-wait allowed: mem_valid may arrive in the first cycle of mem_req.
- Zero-wait neuron latency, BIAS through WRITE:
  - Layer 0: 2 + 4*L1_GROUPS cycles.
  - Layer 1: 2 + L2_GROUPS*(2+2*LANES) cycles.
- Each memory wait cycle adds exactly one cycle.
- done goes high one cycle after the final WRITE. busy falls together with the return to IDLE.
- Operand registers change only on their capture edges and hold between captures.

## Test plan
- LANES=4, L1_GROUPS=2, L1_NEURONS=3, L2_NEURONS=2, zero-wait memory -> mem_addr runs 0..12 with no gaps; exactly 5 act_wr_en pulses at addresses 0,1,2,3,4; one done pulse.
- Same configuration, check layer-1 inputs -> lane 3 is always 0 and lanes 0–2 equal activation RAM words 0–2.
- Weight wait: mem_valid delayed 3 cycles on address 4 -> mem_addr held at 4 for 4 cycles; each dependent output shifts by exactly 3 cycles.
- abort asserted in the first layer-1 ACCU -> IDLE next cycle with busy=0, no further act_wr_en, no done; a following start restarts at mem_addr=0.
- start pulsed while busy -> ignored; exactly one done per accepted start.
- n_rst asserted mid-WEIGHT -> all outputs 0 immediately; after release, state is IDLE until start.

Source files
------------

// File: rtl/mlp_sequencer_if.sv
// Bus bundle between mlp_sequencer and its neighbours: weight memory,
// pixel buffer, activation RAM and the multiply-accumulate ALU.
interface mlp_sequencer_if #(
    parameter int DATA_W     = 4,
    parameter int LANES      = 4,
    parameter int L1_GROUPS  = 36,
    parameter int L1_NEURONS = 8,
    parameter int ADDR_W     = 16,
    parameter int ACT_AW     = 5
);
    localparam int L2_GROUPS = (L1_NEURONS + LANES - 1) / LANES;
    localparam int G_MAX     = (L1_GROUPS > L2_GROUPS) ? L1_GROUPS : L2_GROUPS;
    localparam int G_W       = (G_MAX > 1) ? $clog2(G_MAX) : 1;

    logic                    start;
    logic                    abort;
    logic                    busy;
    logic                    done;
    logic                    mem_req;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_valid;
    logic [LANES*DATA_W-1:0] mem_data;
    logic                    pix_req;
    logic [G_W-1:0]          pix_group;
    logic [LANES*DATA_W-1:0] pix_data;
    logic [ACT_AW-1:0]       act_rd_addr;
    logic [DATA_W-1:0]       act_rd_data;
    logic                    act_wr_en;
    logic [ACT_AW-1:0]       act_wr_addr;
    logic [DATA_W-1:0]       act_wr_data;
    logic [DATA_W-1:0]       alu_result;
    logic [LANES*DATA_W-1:0] weights;
    logic [LANES*DATA_W-1:0] inputs;
    logic [DATA_W-1:0]       bias;
    logic                    clear;
    logic                    accumulate;
    logic                    layer;

    modport master (
        input  start, abort, mem_valid, mem_data, pix_data, act_rd_data, alu_result,
        output busy, done, mem_req, mem_addr, pix_req, pix_group, act_rd_addr,
               act_wr_en, act_wr_addr, act_wr_data, weights, inputs, bias,
               clear, accumulate, layer
    );

    modport slave (
        output start, abort, mem_valid, mem_data, pix_data, act_rd_data, alu_result,
        input  busy, done, mem_req, mem_addr, pix_req, pix_group, act_rd_addr,
               act_wr_en, act_wr_addr, act_wr_data, weights, inputs, bias,
               clear, accumulate, layer
    );
endinterface

// File: rtl/mlp_sequencer.sv
// Two-layer inference sequencer: walks every neuron of the hidden and output
// layers, fetching bias/weights, gathering LANES-wide input groups and
// issuing one ALU accumulate per group, then writing the activation back.
module mlp_sequencer #(
    parameter int DATA_W     = 4,
    parameter int LANES      = 4,
    parameter int L1_GROUPS  = 36,
    parameter int L1_NEURONS = 8,
    parameter int L2_NEURONS = 10,
    parameter int ADDR_W     = 16,
    parameter int ACT_AW     = 5
) (
    input  logic            clk,
    input  logic            n_rst,
    mlp_sequencer_if.master bus
);
    localparam int L2_GROUPS = (L1_NEURONS + LANES - 1) / LANES;
    localparam int G_MAX     = (L1_GROUPS > L2_GROUPS) ? L1_GROUPS : L2_GROUPS;
    localparam int G_W       = (G_MAX > 1) ? $clog2(G_MAX) : 1;
    localparam int N_MAX     = (L1_NEURONS > L2_NEURONS) ? L1_NEURONS : L2_NEURONS;
    localparam int N_W       = (N_MAX > 1) ? $clog2(N_MAX) : 1;
    localparam int K_W       = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int OP_W      = LANES * DATA_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BIAS   = 3'd1;
    localparam logic [2:0] S_WEIGHT = 3'd2;
    localparam logic [2:0] S_IN_REQ = 3'd3;
    localparam logic [2:0] S_IN_CAP = 3'd4;
    localparam logic [2:0] S_ACCU   = 3'd5;
    localparam logic [2:0] S_WRITE  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    logic [2:0]        state_reg, state_next;
    logic              layer_reg;
    logic [N_W-1:0]    n_reg;
    logic [G_W-1:0]    g_reg;
    logic [K_W-1:0]    k_reg;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] bias_reg;
    logic [OP_W-1:0]   weights_reg, inputs_reg, inputs_next;

    logic              last_group, last_neuron, last_lane, lane_pad;
    logic [31:0]       rd_idx;
    logic [ACT_AW-1:0] rd_addr, wr_addr;

    assign last_group  = layer_reg ? (g_reg == G_W'(L2_GROUPS - 1))
                                   : (g_reg == G_W'(L1_GROUPS - 1));
    assign last_neuron = layer_reg ? (n_reg == N_W'(L2_NEURONS - 1))
                                   : (n_reg == N_W'(L1_NEURONS - 1));
    assign last_lane   = (k_reg == K_W'(LANES - 1));

    // Hidden activations only fill the first L1_NEURONS slots; lanes past
    // that point are padding and must feed zeros to the ALU.
    assign rd_idx   = 32'(g_reg) * 32'(LANES) + 32'(k_reg);
    assign lane_pad = (rd_idx >= 32'(L1_NEURONS));
    assign rd_addr  = ACT_AW'(g_reg) * ACT_AW'(LANES) + ACT_AW'(k_reg);
    assign wr_addr  = layer_reg ? (ACT_AW'(L1_NEURONS) + ACT_AW'(n_reg)) : ACT_AW'(n_reg);

    // Next input operand: full pixel group in layer 0, one lane at a time in layer 1.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign inputs_next[gi*DATA_W +: DATA_W] =
            !layer_reg              ? bus.pix_data[gi*DATA_W +: DATA_W] :
            (k_reg == K_W'(gi))     ? (lane_pad ? '0 : bus.act_rd_data) :
                                      inputs_reg[gi*DATA_W +: DATA_W];
    end

    // Next-state selection; abort overrides everything.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (bus.start) state_next = S_BIAS;
            S_BIAS:   if (bus.mem_valid) state_next = S_WEIGHT;
            S_WEIGHT: if (bus.mem_valid) state_next = S_IN_REQ;
            S_IN_REQ: state_next = S_IN_CAP;
            S_IN_CAP: state_next = (!layer_reg || last_lane) ? S_ACCU : S_IN_REQ;
            S_ACCU:   state_next = last_group ? S_WRITE : S_WEIGHT;
            S_WRITE:  state_next = (layer_reg && last_neuron) ? S_DONE : S_BIAS;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (bus.abort) state_next = S_IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // Sequencing counters; cleared on every entry to (and stay in) IDLE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            layer_reg <= 1'b0;
            n_reg     <= '0;
            g_reg     <= '0;
            k_reg     <= '0;
            a_reg     <= '0;
        end else if (state_next == S_IDLE) begin
            layer_reg <= 1'b0;
            n_reg     <= '0;
            g_reg     <= '0;
            k_reg     <= '0;
            a_reg     <= '0;
        end else begin
            case (state_reg)
                S_BIAS: begin
                    g_reg <= '0;
                    if (bus.mem_valid) a_reg <= a_reg + ADDR_W'(1);
                end
                S_WEIGHT: if (bus.mem_valid) a_reg <= a_reg + ADDR_W'(1);
                S_IN_CAP: if (layer_reg) k_reg <= last_lane ? '0 : k_reg + K_W'(1);
                S_ACCU:   if (!last_group) g_reg <= g_reg + G_W'(1);
                S_WRITE: begin
                    if (!last_neuron) begin
                        n_reg <= n_reg + N_W'(1);
                    end else if (!layer_reg) begin
                        layer_reg <= 1'b1;
                        n_reg     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ALU operand registers; they only move on their own capture edges.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bias_reg    <= '0;
            weights_reg <= '0;
            inputs_reg  <= '0;
        end else if (!bus.abort) begin
            if (state_reg == S_BIAS && bus.mem_valid)   bias_reg    <= bus.mem_data[DATA_W-1:0];
            if (state_reg == S_WEIGHT && bus.mem_valid) weights_reg <= bus.mem_data;
            if (state_reg == S_IN_CAP)                  inputs_reg  <= inputs_next;
        end
    end

    assign bus.busy        = (state_reg != S_IDLE);
    assign bus.done        = (state_reg == S_DONE);
    assign bus.mem_req     = (state_reg == S_BIAS) || (state_reg == S_WEIGHT);
    assign bus.mem_addr    = a_reg;
    assign bus.pix_req     = (state_reg == S_IN_REQ) && !layer_reg;
    assign bus.pix_group   = bus.pix_req ? g_reg : '0;
    assign bus.act_rd_addr = ((state_reg == S_IN_REQ) && layer_reg) ? rd_addr : '0;
    assign bus.act_wr_en   = (state_reg == S_WRITE);
    assign bus.act_wr_addr = bus.act_wr_en ? wr_addr : '0;
    assign bus.act_wr_data = bus.act_wr_en ? bus.alu_result : '0;
    assign bus.weights     = weights_reg;
    assign bus.inputs      = inputs_reg;
    assign bus.bias        = bias_reg;
    assign bus.clear       = (state_reg == S_BIAS);
    assign bus.accumulate  = (state_reg == S_ACCU);
    assign bus.layer       = layer_reg;
endmodule

// File: tb/tb_mlp_sequencer.sv
// Directed bench for mlp_sequencer in a small 2-group / 3-hidden / 2-output
// configuration, with memory, pixel buffer, activation RAM and ALU models.
module tb_mlp_sequencer;
    localparam int DATA_W     = 4;
    localparam int LANES      = 4;
    localparam int L1_GROUPS  = 2;
    localparam int L1_NEURONS = 3;
    localparam int L2_NEURONS = 2;
    localparam int ADDR_W     = 16;
    localparam int ACT_AW     = 5;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic tb_clr = 1'b1;
    always #5 clk = ~clk;

    mlp_sequencer_if #(.DATA_W(DATA_W), .LANES(LANES), .L1_GROUPS(L1_GROUPS),
                       .L1_NEURONS(L1_NEURONS), .ADDR_W(ADDR_W), .ACT_AW(ACT_AW)) bus ();

    mlp_sequencer #(.DATA_W(DATA_W), .LANES(LANES), .L1_GROUPS(L1_GROUPS),
                    .L1_NEURONS(L1_NEURONS), .L2_NEURONS(L2_NEURONS),
                    .ADDR_W(ADDR_W), .ACT_AW(ACT_AW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    typedef struct { logic [3:0] bias; logic [15:0] w; logic [15:0] in; } acc_t;
    typedef struct { logic [4:0] addr; logic [3:0] data; int cyc; } wr_t;

    int   exp_addr_q[$];
    acc_t exp_acc_q[$];
    wr_t  exp_wr_q[$];

    int n_cmp = 0, n_err = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, addr4_cycles = 0;
    int stall_addr = -1, stall_len = 0, wait_cnt = 0, alu_seq = 0;
    logic [3:0] act_ram [32];

    function automatic logic [15:0] mem_pat(input int a);
        return 16'(a * 32'h1357 + 32'h2468);
    endfunction

    function automatic logic [15:0] pix_pat(input int g);
        return 16'hC0DE ^ 16'(g * 32'h1111);
    endfunction

    // Weight memory: word valid once the programmed wait for that address has elapsed.
    assign bus.mem_valid  = bus.mem_req &&
                            (wait_cnt >= ((int'(bus.mem_addr) == stall_addr) ? stall_len : 0));
    assign bus.mem_data   = bus.mem_req ? mem_pat(int'(bus.mem_addr)) : '0;
    assign bus.alu_result = 4'hA ^ 4'(alu_seq);

    // Registered neighbours: memory wait counter, pixel buffer, activation RAM, ALU sequence.
    always @(posedge clk) begin
        if (!bus.mem_req || bus.mem_valid) wait_cnt <= 0;
        else                               wait_cnt <= wait_cnt + 1;
        if (bus.pix_req) bus.pix_data <= pix_pat(int'(bus.pix_group));
        bus.act_rd_data <= act_ram[bus.act_rd_addr];
        if (tb_clr) begin
            for (int i = 0; i < 32; i++) act_ram[i] <= 4'hF;
            alu_seq <= 0;
        end else if (bus.act_wr_en) begin
            act_ram[bus.act_wr_addr] <= bus.act_wr_data;
            alu_seq <= alu_seq + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, {bus.busy, bus.done, bus.mem_req, bus.pix_req, bus.act_wr_en,
                             bus.clear, bus.accumulate, bus.layer}, 0);
        chk({tag, "_addr"}, {bus.mem_addr, bus.pix_group, bus.act_rd_addr, bus.act_wr_addr,
                             bus.act_wr_data, bus.bias}, 0);
        chk({tag, "_operands"}, {bus.weights, bus.inputs}, 0);
    endtask

    // One clock: sample on the falling edge and score every DUT transaction.
    task automatic cycle();
        acc_t ae;
        wr_t  we;
        @(negedge clk);
        cyc++;
        if (bus.mem_req && int'(bus.mem_addr) == 4) addr4_cycles++;
        if (bus.mem_req && bus.mem_valid) begin
            chk("mem_fetch_expected", exp_addr_q.size() > 0, 1);
            if (exp_addr_q.size() > 0) chk("mem_addr", bus.mem_addr, exp_addr_q.pop_front());
        end
        if (bus.accumulate) begin
            chk("acc_expected", exp_acc_q.size() > 0, 1);
            if (exp_acc_q.size() > 0) begin
                ae = exp_acc_q.pop_front();
                chk("acc_bias", bus.bias, ae.bias);
                chk("acc_weights", bus.weights, ae.w);
                chk("acc_inputs", bus.inputs, ae.in);
            end
        end
        if (bus.act_wr_en) begin
            chk("wr_expected", exp_wr_q.size() > 0, 1);
            if (exp_wr_q.size() > 0) begin
                we = exp_wr_q.pop_front();
                $display("write addr=%0d data=%0h cycle=%0d", bus.act_wr_addr, bus.act_wr_data, cyc);
                chk("wr_addr", bus.act_wr_addr, we.addr);
                chk("wr_data", bus.act_wr_data, we.data);
                chk("wr_cycle", cyc, we.cyc);
            end
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            $display("done cycle=%0d", cyc);
        end
    endtask

    // Expected transactions of one full inference; st = extra wait cycles on address 4.
    task automatic push_inference(input int st);
        acc_t ae;
        wr_t  we;
        logic [15:0] t;
        for (int a = 0; a < 13; a++) exp_addr_q.push_back(a);
        for (int j = 0; j < 3; j++) begin
            for (int g = 0; g < 2; g++) begin
                t = mem_pat(3 * j);
                ae.bias = t[3:0];
                ae.w    = mem_pat(3 * j + 1 + g);
                ae.in   = pix_pat(g);
                exp_acc_q.push_back(ae);
            end
            we.addr = 5'(j);
            we.data = 4'hA ^ 4'(j);
            we.cyc  = 10 * (j + 1) + ((j >= 1) ? st : 0);
            exp_wr_q.push_back(we);
        end
        for (int n = 0; n < 2; n++) begin
            t = mem_pat(9 + 2 * n);
            ae.bias = t[3:0];
            ae.w    = mem_pat(10 + 2 * n);
            ae.in   = 16'h08BA;
            exp_acc_q.push_back(ae);
            we.addr = 5'(3 + n);
            we.data = 4'hA ^ 4'(3 + n);
            we.cyc  = 42 + 12 * n + st;
            exp_wr_q.push_back(we);
        end
    endtask

    task automatic flush_queues();
        exp_addr_q.delete();
        exp_acc_q.delete();
        exp_wr_q.delete();
    endtask

    task automatic start_run();
        tb_clr = 1'b1;
        cycle();
        tb_clr = 1'b0;
        bus.start = 1'b1;
        cyc = 0;
        cycle();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input int exp_cyc);
        int d0;
        int i;
        d0 = done_cnt;
        i = 0;
        while (done_cnt == d0 && i < limit) begin
            cycle();
            i++;
        end
        chk("done_seen", done_cnt - d0, 1);
        chk("done_cycle", done_cyc, exp_cyc);
        chk("addr_q_drained", exp_addr_q.size(), 0);
        chk("acc_q_drained", exp_acc_q.size(), 0);
        chk("wr_q_drained", exp_wr_q.size(), 0);
        cycle();
        chk("busy_after_done", bus.busy, 0);
        chk("done_one_cycle", bus.done, 0);
    endtask

    initial begin
        int i;
        int d_before;
        bus.start = 1'b0;
        bus.abort = 1'b0;

        // Reset state
        repeat (3) cycle();
        check_zero("reset");
        n_rst = 1'b1;
        tb_clr = 1'b0;
        repeat (2) cycle();
        chk("idle_without_start", bus.busy, 0);

        // Zero-wait inference
        push_inference(0);
        start_run();
        wait_done(200, 55);

        // Three wait cycles on address 4
        stall_addr = 4;
        stall_len = 3;
        addr4_cycles = 0;
        push_inference(3);
        start_run();
        wait_done(200, 58);
        chk("addr4_hold_cycles", addr4_cycles, 4);
        stall_addr = -1;
        stall_len = 0;

        // Abort in the first layer-1 accumulate
        push_inference(0);
        start_run();
        i = 0;
        while (!(bus.accumulate && bus.layer) && i < 200) begin
            cycle();
            i++;
        end
        chk("abort_point_reached", bus.accumulate & bus.layer, 1);
        bus.abort = 1'b1;
        cycle();
        bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_addr_left", exp_addr_q.size(), 2);
        chk("abort_wr_left", exp_wr_q.size(), 2);
        flush_queues();
        d_before = done_cnt;
        repeat (20) cycle();
        chk("abort_no_done", done_cnt - d_before, 0);
        chk("abort_still_idle", bus.busy, 0);
        push_inference(0);
        start_run();
        wait_done(200, 55);

        // start pulsed while busy is ignored
        d_before = done_cnt;
        push_inference(0);
        start_run();
        repeat (20) cycle();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        wait_done(200, 55);
        repeat (10) cycle();
        chk("single_done", done_cnt - d_before, 1);
        chk("idle_after_busy_start", bus.busy, 0);

        // Reset asserted mid-WEIGHT
        push_inference(0);
        start_run();
        i = 0;
        while (!(bus.mem_req && !bus.clear) && i < 50) begin
            cycle();
            i++;
        end
        chk("weight_state_reached", bus.mem_req & ~bus.clear, 1);
        n_rst = 1'b0;
        #1;
        check_zero("reset_mid_weight");
        flush_queues();
        repeat (3) cycle();
        n_rst = 1'b1;
        repeat (5) cycle();
        chk("post_reset_busy", bus.busy, 0);
        chk("post_reset_mem_req", bus.mem_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
